// File: rtl/dft_pkg.sv
// Shared DFT constants, complex sample type and index helpers.
// Imported by the loader, its bank array and later rank controllers.
package dft_pkg;

    localparam int WORD_SZ       = 32;
    localparam int WORD_MIDPOINT = 16;
    localparam int N_POINTS      = 16;
    localparam int LOG2_N        = 4;

    // Widest index bitrev() can handle; callers pass the live width.
    localparam int BITREV_MAX    = 16;

    // Real half occupies the upper bits, imaginary half the lower bits.
    typedef struct packed {
        logic signed [WORD_SZ-WORD_MIDPOINT-1:0] re;
        logic signed [WORD_MIDPOINT-1:0]         im;
    } cplx_t;

    // Reverse the low nbits of idx.  The full-width reversal pushes the
    // wanted bits to the top, so a right shift brings them back down.
    function automatic logic [BITREV_MAX-1:0] bitrev(
        input logic [BITREV_MAX-1:0] idx,
        input int                    nbits
    );
        logic [BITREV_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX; i++) begin
            r[BITREV_MAX-1-i] = idx[i];
        end
        return r >> (BITREV_MAX - nbits);
    endfunction

endpackage

// File: rtl/dft_pingpong_bank.sv
// Two-bank sample store: one write port, two asynchronous read ports.
// Ports: i_CLK; i_we/i_waddr/i_wdata write; i_raddr_a/b -> o_rdata_a/b.
// Addresses are {bank, addr}; contents are never reset.
module dft_pingpong_bank
    import dft_pkg::*;
#(
    parameter int DW = dft_pkg::WORD_SZ,
    parameter int AW = dft_pkg::LOG2_N + 1
) (
    input  logic          i_CLK,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge i_CLK) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = mem_q[i_raddr_a];
    assign o_rdata_b = mem_q[i_raddr_b];

endmodule

// File: rtl/dft_bitrev_loader.sv
// DFT input stage: ping-pong frame buffer, natural order in, radix-2
// operand pairs out in bit-reversed order.
// Ports: i_CLK, i_RST (async, active-high);
//   write side i_valid/i_data/o_ready (one sample per cycle);
//   read side  o_valid/o_A/o_B/o_pair_idx/o_last with i_ready.
module dft_bitrev_loader
    import dft_pkg::*;
#(
    parameter int N_POINTS = dft_pkg::N_POINTS,
    parameter int LOG2_N   = dft_pkg::LOG2_N,
    parameter int WORD_SZ  = dft_pkg::WORD_SZ
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_valid,
    input  logic [WORD_SZ-1:0]  i_data,
    output logic                o_ready,
    output logic                o_valid,
    output logic [WORD_SZ-1:0]  o_A,
    output logic [WORD_SZ-1:0]  o_B,
    output logic [LOG2_N-2:0]   o_pair_idx,
    output logic                o_last,
    input  logic                i_ready
);

    localparam int PW = LOG2_N - 1;
    localparam int AW = LOG2_N + 1;

    localparam logic [LOG2_N-1:0] WCNT_LAST = LOG2_N'(N_POINTS - 1);
    localparam logic [PW-1:0]     RCNT_LAST = PW'(N_POINTS / 2 - 1);

    // Write side state
    logic              wbank_q, wbank_d;
    logic [LOG2_N-1:0] wcnt_q,  wcnt_d;

    // Read side state
    logic              rbank_q, rbank_d;
    logic [PW-1:0]     rcnt_q,  rcnt_d;

    // One full flag per bank, indexed by bank number
    logic [1:0]        full_q,  full_d;

    // Output register
    logic              valid_q, valid_d;
    logic [WORD_SZ-1:0] a_q,    a_d;
    logic [WORD_SZ-1:0] b_q,    b_d;
    logic [PW-1:0]     idx_q,   idx_d;
    logic              last_q,  last_d;

    logic              wr_fire;
    logic              wr_done;
    logic              rd_load;
    logic              rd_done;

    logic [LOG2_N-1:0] addr_a;
    logic [LOG2_N-1:0] addr_b;
    logic [WORD_SZ-1:0] rd_a;
    logic [WORD_SZ-1:0] rd_b;

    // Writer only ever targets a non-full bank; derived from flops only.
    assign o_ready = !full_q[wbank_q];

    assign wr_fire = i_valid && o_ready;
    assign wr_done = wr_fire && (wcnt_q == WCNT_LAST);

    // Load a new pair whenever the output slot is free or being taken.
    assign rd_load = full_q[rbank_q] && (!valid_q || i_ready);
    assign rd_done = rd_load && (rcnt_q == RCNT_LAST);

    // rev(2k) and rev(2k+1); the latter is rev(2k) + N/2.
    assign addr_a = LOG2_N'(bitrev(BITREV_MAX'({rcnt_q, 1'b0}), LOG2_N));
    assign addr_b = LOG2_N'(bitrev(BITREV_MAX'({rcnt_q, 1'b1}), LOG2_N));

    dft_pingpong_bank #(
        .DW (WORD_SZ),
        .AW (AW)
    ) u_bank (
        .i_CLK     (i_CLK),
        .i_we      (wr_fire),
        .i_waddr   ({wbank_q, wcnt_q}),
        .i_wdata   (i_data),
        .i_raddr_a ({rbank_q, addr_a}),
        .i_raddr_b ({rbank_q, addr_b}),
        .o_rdata_a (rd_a),
        .o_rdata_b (rd_b)
    );

    always_comb begin
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        full_d  = full_q;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        last_d  = last_q;

        if (wr_fire) begin
            // Counter is exactly LOG2_N bits, so N-1 wraps to 0.
            wcnt_d = wcnt_q + LOG2_N'(1);
            if (wr_done) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        // Completed and released banks always differ, so both updates
        // to full_d may land on the same edge without interfering.
        if (rd_load) begin
            valid_d = 1'b1;
            a_d     = rd_a;
            b_d     = rd_b;
            idx_d   = rcnt_q;
            last_d  = (rcnt_q == RCNT_LAST);
            rcnt_d  = rcnt_q + PW'(1);
            if (rd_done) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            wbank_q <= 1'b0;
            wcnt_q  <= '0;
            rbank_q <= 1'b0;
            rcnt_q  <= '0;
            full_q  <= '0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            wbank_q <= wbank_d;
            wcnt_q  <= wcnt_d;
            rbank_q <= rbank_d;
            rcnt_q  <= rcnt_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_A        = a_q;
    assign o_B        = b_q;
    assign o_pair_idx = idx_q;
    assign o_last     = last_q;

endmodule

// File: tb/tb_dft_bitrev_loader.sv
// Scoreboard bench for dft_bitrev_loader.
// Frames are modelled as sample queues; pairs follow from index reversal.
module tb_dft_bitrev_loader;

    localparam int N  = 16;
    localparam int LG = 4;
    localparam int W  = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           idx;
        bit           last;
    } pair_t;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [W-1:0]  i_data;
    logic          o_ready;
    logic          o_valid;
    logic [W-1:0]  o_A;
    logic [W-1:0]  o_B;
    logic [LG-2:0] o_pair_idx;
    logic          o_last;
    logic          i_ready;

    pair_t        exp_q[$];
    logic [W-1:0] cur[$];

    int  n_cmp = 0;
    int  n_err = 0;
    int  n_acc = 0;
    int  n_pop = 0;
    bit  chk_ready = 0;

    dft_bitrev_loader #(
        .N_POINTS (N),
        .LOG2_N   (LG),
        .WORD_SZ  (W)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_A        (o_A),
        .o_B        (o_B),
        .o_pair_idx (o_pair_idx),
        .o_last     (o_last),
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Reverse LG bits of i by repeated halving.
    function automatic int rev(input int i);
        int r = 0;
        int v = i;
        for (int b = 0; b < LG; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Input monitor: record accepted samples, emit expected pairs.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_ready) chk("o_ready_held", o_ready, 1);
            if (i_valid && o_ready) begin
                cur.push_back(i_data);
                n_acc++;
                if (cur.size() == N) begin
                    for (int k = 0; k < N / 2; k++) begin
                        pair_t p;
                        p.a    = cur[rev(2 * k)];
                        p.b    = cur[rev(2 * k + 1)];
                        p.idx  = k;
                        p.last = (k == N / 2 - 1);
                        exp_q.push_back(p);
                    end
                    cur.delete();
                end
            end
        end
    end

    // Output monitor: every presented pair must match the queue head,
    // including while held under backpressure.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pair: got A=%0h B=%0h required none",
                         o_A, o_B);
            end else begin
                chk("pair_A", o_A, exp_q[0].a);
                chk("pair_B", o_B, exp_q[0].b);
                chk("pair_idx", o_pair_idx, exp_q[0].idx);
                chk("pair_last", o_last, exp_q[0].last);
                if (i_ready) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d,
                         input logic r);
        @(posedge clk);
        #1;
        i_valid = v;
        i_data  = d;
        i_ready = r;
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        cur.delete();
        exp_q.delete();
        #1;
        chk({nm, "_valid"}, o_valid, 0);
        chk({nm, "_A"}, o_A, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk({nm, "_ready"}, o_ready, 1);
    endtask

    task automatic drain(input string nm);
        int i;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_valid) break;
        end
        chk({nm, "_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string nm);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1;
                break;
            end
        end
        chk({nm, "_seen"}, seen, 1);
    endtask

    initial begin
        int base;
        bit seen;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_A", o_A, 0);
        chk("rst_B", o_B, 0);
        chk("rst_idx", o_pair_idx, 0);
        chk("rst_last", o_last, 0);

        // Single frame, index values, latency check
        for (int i = 0; i < N; i++) drive(1, W'(i), 1);
        drive(0, 0, 1);
        @(negedge clk);
        chk("lat_early", o_valid, 0);
        @(negedge clk);
        chk("lat_valid", o_valid, 1);
        chk("lat_A", o_A, 0);
        chk("lat_B", o_B, 8);
        drain("single");

        // Sign fidelity: most-negative real, most-positive imag
        for (int i = 0; i < N; i++)
            drive(1, (i == 8) ? 32'h8000_7FFF : $urandom, 0);
        wait_valid("sign");
        chk("sign_B", o_B, 32'h8000_7FFF);
        drain("sign");

        // Streaming: 4 back-to-back frames
        base = n_pop;
        chk_ready = 1;
        for (int i = 0; i < 4 * N; i++) drive(1, $urandom, 1);
        @(negedge clk);
        chk_ready = 0;
        drain("stream");
        chk("stream_pairs", n_pop - base, 32);

        // Backpressure: fill both banks with the reader stalled
        base = n_acc;
        for (int i = 0; i < 40; i++) begin
            drive(1, $urandom, 0);
            @(negedge clk);
            if (!o_ready) break;
        end
        chk("bp_accepted", n_acc - base, 32);
        chk("bp_valid", o_valid, 1);
        chk("bp_idx", o_pair_idx, 0);
        repeat (3) drive(1, $urandom, 0);
        base = n_pop;
        seen = 0;
        i_valid = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            drive(0, 0, 1);
            @(negedge clk);
            if (o_valid && o_last) begin
                chk("bp_ready_rise", o_ready, 1);
                seen = 1;
            end else begin
                chk("bp_ready_low", o_ready, 0);
            end
        end
        drain("bp");
        chk("bp_pairs", n_pop - base, 16);

        // Reset while pair 3 is pending
        for (int i = 0; i < N; i++) drive(1, $urandom, 1);
        for (int i = 0; i < 30; i++) begin
            drive(0, 0, 1);
            @(negedge clk);
            if (o_valid && o_pair_idx == 2) break;
        end
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        @(negedge clk);
        chk("p3_valid", o_valid, 1);
        chk("p3_idx", o_pair_idx, 3);
        do_reset("rst_p3");

        // Reset after a partial frame of 7 samples
        for (int i = 0; i < 7; i++) drive(1, $urandom, 1);
        do_reset("rst_mid");
        for (int i = 0; i < N; i++) drive(1, W'(100 + i), 0);
        wait_valid("post_rst");
        chk("post_rst_A", o_A, 100);
        chk("post_rst_B", o_B, 108);
        drain("post_rst");

        // Bank 1 fill lands on the same edge as bank 0's last pair
        base = n_pop;
        chk_ready = 1;
        for (int c = 0; c < 3 * N; c++)
            drive(1, $urandom, !(c >= 17 && c <= 24));
        @(negedge clk);
        chk_ready = 0;
        drain("same_edge");
        chk("same_edge_pairs", n_pop - base, 24);

        // Random traffic on both handshakes
        for (int i = 0; i < 800; i++)
            drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
